// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin write-back arbiter with per-register busy scoreboard
module regfile_wb_arbiter #(
  parameter int NREQ   = 3,
  parameter int ADDR_W = 3,
  parameter int DATA_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_addr,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic                   rf_we,
  output logic [ADDR_W-1:0]      rf_w_add,
  output logic [DATA_W-1:0]      rf_w_data,
  input  logic                   rsv_valid,
  input  logic [ADDR_W-1:0]      rsv_addr,
  output logic                   rsv_conflict,
  input  logic [ADDR_W-1:0]      chk_add1,
  input  logic [ADDR_W-1:0]      chk_add2,
  output logic                   hazard1,
  output logic                   hazard2,
  output logic [(1<<ADDR_W)-1:0] busy
);
  localparam int NR = 1 << ADDR_W;
  localparam int PTR_W = NREQ > 1 ? $clog2(NREQ) : 1;
  localparam logic [PTR_W:0] NREQ_W = (PTR_W+1)'(NREQ);
  localparam logic [PTR_W-1:0] LAST = PTR_W'(NREQ - 1);
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic              rf_we_q, rf_we_d;
  logic [ADDR_W-1:0] rf_w_add_q, rf_w_add_d;
  logic [DATA_W-1:0] rf_w_data_q, rf_w_data_d;
  logic              rsv_conflict_q, rsv_conflict_d;
  logic [NR-1:0]     busy_q, busy_d;
  logic              gnt_vld;
  logic [PTR_W-1:0]  gnt_idx, idx;
  logic [PTR_W:0]    sum;
  logic [ADDR_W-1:0] g_addr;
  logic [DATA_W-1:0] g_data;
  // Scan from ptr with wrap; walking backwards lets the nearest valid requester win.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum = '0;
    idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      sum = {1'b0, ptr_q} + (PTR_W+1)'(k);
      idx = PTR_W'(sum >= NREQ_W ? sum - NREQ_W : sum);
      if (req_valid[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end
  // Decode the grant into ready and mux out the winning address/data.
  always_comb begin
    req_ready = '0;
    g_addr = '0;
    g_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_vld && gnt_idx == PTR_W'(i)) begin
        req_ready[i] = 1'b1;
        g_addr = req_addr[i*ADDR_W +: ADDR_W];
        g_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end
  // Next state: pointer advance, R0-dropping write stage, scoreboard with set-over-clear.
  always_comb begin
    ptr_d = gnt_vld ? (gnt_idx == LAST ? '0 : gnt_idx + 1'b1) : ptr_q;
    rf_we_d = gnt_vld && g_addr != '0;
    rf_w_add_d = rf_we_d ? g_addr : rf_w_add_q;
    rf_w_data_d = rf_we_d ? g_data : rf_w_data_q;
    rsv_conflict_d = rsv_valid && rsv_addr != '0 && busy_q[rsv_addr];
    busy_d = '0;
    for (int r = 1; r < NR; r++)
      busy_d[r] = (rsv_valid && rsv_addr == ADDR_W'(r)) || (busy_q[r] && !(gnt_vld && g_addr == ADDR_W'(r)));
  end
  // State registers; async reset also kills any in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr_q <= '0;
      rf_we_q <= 1'b0;
      rf_w_add_q <= '0;
      rf_w_data_q <= '0;
      rsv_conflict_q <= 1'b0;
      busy_q <= '0;
    end else begin
      ptr_q <= ptr_d;
      rf_we_q <= rf_we_d;
      rf_w_add_q <= rf_w_add_d;
      rf_w_data_q <= rf_w_data_d;
      rsv_conflict_q <= rsv_conflict_d;
      busy_q <= busy_d;
    end
  end
  assign rf_we = rf_we_q;
  assign rf_w_add = rf_w_add_q;
  assign rf_w_data = rf_w_data_q;
  assign rsv_conflict = rsv_conflict_q;
  assign busy = busy_q;
  assign hazard1 = (chk_add1 != '0) && (busy_q[chk_add1] || (rf_we_q && rf_w_add_q == chk_add1));
  assign hazard2 = (chk_add2 != '0) && (busy_q[chk_add2] || (rf_we_q && rf_w_add_q == chk_add2));
endmodule
